// File: rtl/centroid_tracker.sv
// Per-colour centroid tracker: debounces presence, coasts through dropouts, smooths position and
// reports per-frame motion. Define CENTROID_TRACKER_GATE_EN to reject jumps larger than GATE.
module centroid_tracker #(
    parameter int ACQ_FRAMES  = 3,
    parameter int LOST_FRAMES = 4,
    parameter int DEAD_BAND   = 4,
    parameter int ALPHA_SHIFT = 2,
    parameter int GATE        = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] x_avg,
    input  logic [11:0] y_avg,
    input  logic        frame_done,
    output logic [11:0] x_pos,
    output logic [11:0] y_pos,
    output logic [12:0] dx,
    output logic [12:0] dy,
    output logic [3:0]  dir,
    output logic        locked,
    output logic        track_valid,
    output logic        lost
);

`ifdef CENTROID_TRACKER_GATE_EN
    localparam bit GATE_EN = 1'b1;
`else
    localparam bit GATE_EN = 1'b0;
`endif

    localparam logic [3:0]         ACQ_LAST = 4'(ACQ_FRAMES - 1);
    localparam logic [3:0]         LOST_LIM = 4'(LOST_FRAMES);
    localparam logic [12:0]        GATE_LIM = 13'(GATE);
    localparam logic signed [12:0] DB_POS   = 13'(DEAD_BAND);
    localparam logic signed [12:0] DB_NEG   = -DB_POS;

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        TRACK,
        COAST
    } state_t;

    state_t      state, state_next;

    logic [11:0] cap_x, cap_y;
    logic        cap_valid;
    logic        busy;

    logic [3:0]  acq_cnt, acq_next;
    logic [3:0]  miss_cnt, miss_next;
    logic [11:0] last_x, last_y, last_x_next, last_y_next;
    logic [11:0] pos_x_next, pos_y_next;
    logic [12:0] dx_next, dy_next;
    logic [3:0]  dir_next;
    logic        lost_next;

    logic               raw_present;
    logic               gate_reject;
    logic               meas_ok;
    logic signed [12:0] delta_x, delta_y;
    logic signed [12:0] diff_x, diff_y;
    logic signed [12:0] step_x, step_y;
    logic [12:0]        mag_x, mag_y;
    logic [11:0]        smooth_x, smooth_y;
    logic [3:0]         dir_calc;

    // A new frame is only accepted once both pipeline cycles have drained.
    assign busy = cap_valid | track_valid;

    assign raw_present = (cap_x != 12'd0) || (cap_y != 12'd0);

    assign delta_x = $signed({1'b0, cap_x}) - $signed({1'b0, last_x});
    assign delta_y = $signed({1'b0, cap_y}) - $signed({1'b0, last_y});

    assign diff_x   = $signed({1'b0, cap_x}) - $signed({1'b0, x_pos});
    assign diff_y   = $signed({1'b0, cap_y}) - $signed({1'b0, y_pos});
    assign step_x   = diff_x >>> ALPHA_SHIFT;
    assign step_y   = diff_y >>> ALPHA_SHIFT;
    assign smooth_x = 12'({1'b0, x_pos} + step_x);
    assign smooth_y = 12'({1'b0, y_pos} + step_y);

    assign mag_x       = delta_x[12] ? -delta_x : delta_x;
    assign mag_y       = delta_y[12] ? -delta_y : delta_y;
    assign gate_reject = GATE_EN && ((mag_x > GATE_LIM) || (mag_y > GATE_LIM));
    assign meas_ok     = raw_present && !gate_reject;

    // Bit order {up, down, left, right}; y grows downwards.
    assign dir_calc = {delta_y < DB_NEG, delta_y > DB_POS, delta_x < DB_NEG, delta_x > DB_POS};

    assign locked = (state == TRACK) || (state == COAST);

    // NOTE: every combinational output gets a default before the case so no path can infer a latch.
    always_comb begin
        state_next  = state;
        acq_next    = acq_cnt;
        miss_next   = miss_cnt;
        last_x_next = last_x;
        last_y_next = last_y;
        pos_x_next  = x_pos;
        pos_y_next  = y_pos;
        dx_next     = dx;
        dy_next     = dy;
        dir_next    = dir;
        lost_next   = 1'b0;

        if (cap_valid) begin
            dx_next  = '0;
            dy_next  = '0;
            dir_next = '0;
            case (state)
                IDLE: begin
                    if (raw_present) begin
                        state_next = ACQUIRE;
                        acq_next   = 4'd1;
                    end
                end
                ACQUIRE: begin
                    if (!raw_present) begin
                        state_next = IDLE;
                        acq_next   = '0;
                    end else if (acq_cnt == ACQ_LAST) begin
                        state_next  = TRACK;
                        acq_next    = '0;
                        last_x_next = cap_x;
                        last_y_next = cap_y;
                        pos_x_next  = cap_x;
                        pos_y_next  = cap_y;
                    end else if (acq_cnt != 4'hF) begin
                        acq_next = acq_cnt + 4'd1;
                    end
                end
                TRACK, COAST: begin
                    if (meas_ok) begin
                        state_next  = TRACK;
                        miss_next   = '0;
                        dx_next     = delta_x;
                        dy_next     = delta_y;
                        dir_next    = dir_calc;
                        last_x_next = cap_x;
                        last_y_next = cap_y;
                        pos_x_next  = smooth_x;
                        pos_y_next  = smooth_y;
                    end else if (state == TRACK) begin
                        state_next = COAST;
                        miss_next  = 4'd1;
                    end else if (miss_cnt == LOST_LIM) begin
                        state_next = IDLE;
                        miss_next  = '0;
                        lost_next  = 1'b1;
                    end else if (miss_cnt != 4'hF) begin
                        miss_next = miss_cnt + 4'd1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_x       <= '0;
            cap_y       <= '0;
            cap_valid   <= 1'b0;
            track_valid <= 1'b0;
            lost        <= 1'b0;
            acq_cnt     <= '0;
            miss_cnt    <= '0;
            last_x      <= '0;
            last_y      <= '0;
            x_pos       <= '0;
            y_pos       <= '0;
            dx          <= '0;
            dy          <= '0;
            dir         <= '0;
        end else begin
            cap_valid   <= frame_done && !busy;
            if (frame_done && !busy) begin
                cap_x <= x_avg;
                cap_y <= y_avg;
            end
            track_valid <= cap_valid;
            lost        <= lost_next;
            acq_cnt     <= acq_next;
            miss_cnt    <= miss_next;
            last_x      <= last_x_next;
            last_y      <= last_y_next;
            x_pos       <= pos_x_next;
            y_pos       <= pos_y_next;
            dx          <= dx_next;
            dy          <= dy_next;
            dir         <= dir_next;
        end
    end

endmodule
